// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and a
// constant-evaluable log2 helper used to size the digit counter.
package serial_adder_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational ripple of DIGIT full-adder cells; one digit of the serial adder.
module digit_adder #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co
);

   logic c;

   always_comb begin
      c = ci;
      s = '0;
      for (int i = 0; i < DIGIT; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      co = c;
   end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle WIDTH-bit adder, DIGIT bits per clock, start/done handshake.
// Optional subtract mode (Sub port) enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             Sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   generate
      if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
         $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT");
      end
   endgenerate

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc_nxt;
   logic [DIGIT-1:0] ds;
   logic             dc;
   logic             accept;
   logic             last;
   logic             sub_sel;

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_sel = Sub;
`else
   assign sub_sel = 1'b0;
`endif

   assign accept = start && (state == IDLE || state == DONE);
   assign last   = (state == RUN) && (cnt == LAST);
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .a  (a_sh[DIGIT-1:0]),
      .b  (b_sh[DIGIT-1:0]),
      .ci (carry),
      .s  (ds),
      .co (dc)
   );

   // Partial sums enter from the MSB side so the final digit lands in place.
   generate
      if (NDIG == 1) begin : g_single
         assign acc_nxt = ds;
      end else begin : g_multi
         logic [WIDTH-DIGIT-1:0] acc;
         assign acc_nxt = {ds, acc};
         always_ff @(posedge clk) begin
            if (state == RUN)
               acc <= acc_nxt[WIDTH-1:DIGIT];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         carry <= 1'b0;
         Sum   <= '0;
         Cout  <= 1'b0;
      end else if (accept) begin
         state <= RUN;
         cnt   <= '0;
         carry <= sub_sel ? 1'b1 : Cin;
      end else begin
         case (state)
            RUN: begin
               carry <= dc;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  state <= DONE;
                  Sum   <= acc_nxt;
                  Cout  <= dc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Subtraction is A + ~B + 1: invert B at load, carry-in forced to 1 above.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_sh <= A;
         b_sh <= sub_sel ? ~B : B;
      end else if (state == RUN) begin
         a_sh <= a_sh >> DIGIT;
         b_sh <= b_sh >> DIGIT;
      end
   end

endmodule
